if_unit: RTL and testbench
==========================

IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 STALL  in  1  hazard-unit hold of the IF/ID register and PC.
REQ-005 BRANCH_TAKEN  in  1  redirect request from EX (jump/taken branch).
REQ-006 BRANCH_TARGET  in  32  redirect address.
REQ-007 IMEM_READ  out  1  instruction-memory read request.
REQ-008 IMEM_ADDR  out  32  instruction-memory word address.
REQ-009 IMEM_RDATA  in  32  read data; valid in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-010 IMEM_BUSYWAIT  in  1  memory not ready.
REQ-011 ID_PC / ID_PC4 / ID_INST  out  32 each  IF/ID register: fetch PC, PC+4, instruction word (feeds decoder and immediate extender).
REQ-012 ID_VALID  out  1  IF/ID entry holds a real instruction.
REQ-013 FETCH_STALL  out  1  combinational; IF cannot deliver this cycle (global pipeline hold).

Function
REQ-014 FSM states BOOT, FETCH, DRAIN; BOOT lasts exactly one cycle after reset, then FETCH.
REQ-015 BOOT: IMEM_READ=0, FETCH_STALL=1.
REQ-016 FETCH: IMEM_READ=1, IMEM_ADDR=PC; a transaction completes in the cycle IMEM_BUSYWAIT=0.
REQ-017 Completion, no STALL, no BRANCH_TAKEN: next edge ID_PC<=PC, ID_PC4<=PC+4, ID_INST<=IMEM_RDATA, ID_VALID<=1, PC<=PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000); back-to-back one instruction per cycle on zero-wait memory.
REQ-018 FETCH with BUSYWAIT=1, no branch: PC and IF/ID held, ID_VALID<=0 (bubble) unless STALL=1.
REQ-019 STALL=1, no branch: PC and all IF/ID outputs held unchanged; completion handled per REQ-031/032.
REQ-020 BRANCH_TAKEN=1 has priority over STALL and completion: PC<={BRANCH_TARGET[31:2],2'b00}, ID_VALID<=0, ID_INST<=32'h0000_0013 (NOP).
REQ-021 Branch while FETCH transaction outstanding (BUSYWAIT=1): latch old address, go DRAIN.
REQ-022 DRAIN: IMEM_READ=1, IMEM_ADDR=latched old address; on BUSYWAIT=0 discard data, go FETCH at new PC; further branch in DRAIN only updates PC.
REQ-023 Branch in a completing FETCH cycle: fetched word discarded, stay FETCH, next request at target.
REQ-024 FETCH_STALL = BOOT | DRAIN | (FETCH & IMEM_BUSYWAIT & no skid entry).
REQ-025 IMEM_ADDR bits [1:0] always 0.

Reset
REQ-026 RESET=1 at an edge: PC<=RESET_PC, state<=BOOT, ID_PC<=0, ID_PC4<=0, ID_INST<=NOP, ID_VALID<=0, skid entry invalid.
REQ-027 Reset mid-transaction abandons it; IMEM_READ=0 the cycle after the reset edge; RESET overrides STALL and BRANCH_TAKEN.

Configuration
REQ-028 Macro IF_SKID_BUFFER_EN selects a one-entry skid buffer.
REQ-029 Defined: completion during STALL stores {PC, RDATA} in skid, PC<=PC+4, IMEM_READ=0 while full.
REQ-030 Defined: first cycle STALL=0 with skid full loads IF/ID from skid without a memory access; branch invalidates skid.
REQ-031 Undefined: completion during STALL is discarded, IMEM_READ stays 1 at same PC (refetch).
REQ-032 Both builds deliver identical instruction sequences on ID_INST/ID_VALID; only IMEM_READ counts differ.

Structure
REQ-033 FSM state encodings, NOP constant 32'h0000_0013 and RESET_PC default live in the shared encodings include.
REQ-034 One sub-module, if_skid_buffer (one-entry register with valid/load/flush), instantiated only under IF_SKID_BUFFER_EN.

Verification
REQ-035 Reset, zero-wait memory, RESET_PC=0 -> BOOT 1 cycle, then ID_PC 0x0,0x4,0x8 on consecutive cycles, ID_VALID=1.
REQ-036 BUSYWAIT=1 for 3 cycles at PC 0x10 -> FETCH_STALL=1 3 cycles, ID_VALID=0, then ID_PC=0x10 with RDATA.
REQ-037 BRANCH_TAKEN, target 0x103, while BUSYWAIT=1 at 0x20 -> DRAIN holds IMEM_ADDR=0x20 until ready, data dropped, next IMEM_ADDR=0x100.
REQ-038 STALL=1 2 cycles at PC 0x40 -> IF/ID unchanged; skid build: 0x44 delivered without second read; non-skid: 0x44 re-read.
REQ-039 BRANCH_TAKEN and STALL same cycle -> PC=target, ID_VALID=0, ID_INST=NOP.
REQ-040 RESET during DRAIN -> next cycle IMEM_READ=0, PC=RESET_PC, ID_VALID=0.

Source files
------------

// File: rtl/if_unit_pkg.sv
// Shared encodings for the instruction-fetch unit: FSM states, NOP word, reset PC.
// The optional skid buffer is enabled with the IF_SKID_BUFFER_EN macro.
package if_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register with valid/load/flush; flush wins over load.
// Only present in builds that define IF_SKID_BUFFER_EN.
`ifdef IF_SKID_BUFFER_EN
module if_skid_buffer #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout <= '0;
        end else if (load && !flush) begin
            dout <= din;
        end
    end

endmodule
`endif

// File: rtl/if_unit.sv
// Instruction-fetch stage: PC, IMEM request FSM (BOOT/FETCH/DRAIN) and IF/ID register.
// Define IF_SKID_BUFFER_EN to keep a word fetched during a stall instead of refetching it.
module if_unit
    import if_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busywait,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        fetch_stall,
    output if_state_t   dbg_state
);

    // IMEM handshake: a request (imem_read=1) completes in the cycle imem_busywait=0;
    // imem_rdata is only meaningful in that cycle. A started request is never dropped
    // except by reset: a redirect during a pending request waits it out in DRAIN.

    if_state_t   state, state_next;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic        req;
    logic        complete;
    logic        skid_valid;

`ifdef IF_SKID_BUFFER_EN
    logic        skid_load;
    logic        skid_flush;
    logic [63:0] skid_dout;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    assign skid_load  = complete && stall && !branch_taken;
    assign skid_flush = branch_taken || (state == ST_FETCH && skid_valid && !stall);
    assign skid_pc    = skid_dout[63:32];
    assign skid_inst  = skid_dout[31:0];

    if_skid_buffer #(.W(64)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .flush (skid_flush),
        .din   ({pc, imem_rdata}),
        .valid (skid_valid),
        .dout  (skid_dout)
    );
`else
    assign skid_valid = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req         = 1'b0;
        imem_addr   = pc;
        fetch_stall = 1'b0;
        case (state)
            ST_BOOT: begin
                fetch_stall = 1'b1;
                state_next  = ST_FETCH;
            end
            ST_FETCH: begin
                // A full skid entry supplies the next instruction, so no memory access.
                req         = !skid_valid;
                fetch_stall = imem_busywait && !skid_valid;
                if (branch_taken && !skid_valid && imem_busywait) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                req         = 1'b1;
                imem_addr   = drain_addr;
                fetch_stall = 1'b1;
                if (!imem_busywait) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    assign imem_read = req;
    assign complete  = (state == ST_FETCH) && req && !imem_busywait;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_addr <= '0;
        end else if (state == ST_FETCH && state_next == ST_DRAIN) begin
            drain_addr <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= word_align(RESET_PC);
            id_pc    <= '0;
            id_pc4   <= '0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (branch_taken) begin
            pc       <= word_align(branch_target);
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else if (state == ST_FETCH) begin
`ifdef IF_SKID_BUFFER_EN
            if (skid_valid) begin
                if (!stall) begin
                    id_pc    <= skid_pc;
                    id_pc4   <= skid_pc + 32'd4;
                    id_inst  <= skid_inst;
                    id_valid <= 1'b1;
                end
            end else
`endif
            if (complete) begin
                if (!stall) begin
                    id_pc    <= pc;
                    id_pc4   <= pc + 32'd4;
                    id_inst  <= imem_rdata;
                    id_valid <= 1'b1;
                    pc       <= pc + 32'd4;
                end
`ifdef IF_SKID_BUFFER_EN
                else begin
                    pc <= pc + 32'd4;
                end
`endif
            end else if (!stall) begin
                id_valid <= 1'b0;
            end
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_unit.sv
// Directed bench for if_unit with a delivery scoreboard on the IF/ID register.
// Works in both the default and the IF_SKID_BUFFER_EN build.
module tb_if_unit;
    import if_unit_pkg::*;

`ifdef IF_SKID_BUFFER_EN
    localparam logic SKID_BUILD = 1'b1;
`else
    localparam logic SKID_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        fetch_stall;
    if_state_t   dbg_state;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic        s_reset;
    logic        s_stall;
    logic [63:0] exp_e;

    if_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_busywait (imem_busywait),
        .id_pc         (id_pc),
        .id_pc4        (id_pc4),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .fetch_stall   (fetch_stall),
        .dbg_state     (dbg_state)
    );

    // clock / memory model
    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void exp_push(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endfunction

    // scoreboard: a new IF/ID entry appears after an edge with no reset and no stall
    always @(posedge clk) begin
        s_reset = reset;
        s_stall = stall;
        #1;
        if (!s_reset && !s_stall && id_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_delivery: got pc %0h expected none", id_pc);
            end else begin
                exp_e = exp_q.pop_front();
                check("delivery_pc_inst", {id_pc, id_inst}, exp_e);
                check("delivery_pc4", {32'd0, id_pc4}, {32'd0, exp_e[63:32] + 32'd4});
            end
        end
    end

    initial begin
        logic [31:0] exp_pc;
        int unsigned b;

        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        imem_busywait = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state, BOOT for exactly one cycle
        reset = 1'b0;
        #1;
        check("rst_id_valid", {63'd0, id_valid}, 64'd0);
        check("rst_id_inst", {32'd0, id_inst}, {32'd0, NOP_INST});
        check("rst_id_pc", {32'd0, id_pc}, 64'd0);
        check("rst_id_pc4", {32'd0, id_pc4}, 64'd0);
        check("boot_read", {63'd0, imem_read}, 64'd0);
        check("boot_fetch_stall", {63'd0, fetch_stall}, 64'd1);
        check("boot_state", {62'd0, dbg_state}, {62'd0, ST_BOOT});
        @(negedge clk);
        #1;
        check("fetch_state", {62'd0, dbg_state}, {62'd0, ST_FETCH});
        check("fetch0_read", {63'd0, imem_read}, 64'd1);
        check("fetch0_addr", {32'd0, imem_addr}, 64'd0);
        check("fetch0_stall", {63'd0, fetch_stall}, 64'd0);

        // zero-wait back-to-back fetches
        exp_push(32'h0);
        exp_push(32'h4);
        exp_push(32'h8);
        exp_push(32'hC);
        exp_push(32'h10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("seq_id_pc", {32'd0, id_pc}, {32'd0, 32'(i * 4)});
            check("seq_id_valid", {63'd0, id_valid}, 64'd1);
        end
        check("busy_addr", {32'd0, imem_addr}, 64'h10);

        // three wait cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            imem_busywait = 1'b1;
            #1;
            check("busy_fetch_stall", {63'd0, fetch_stall}, 64'd1);
            check("busy_addr_hold", {32'd0, imem_addr}, 64'h10);
            @(negedge clk);
            #1;
            check("busy_bubble", {63'd0, id_valid}, 64'd0);
        end
        imem_busywait = 1'b0;
        #1;
        check("ready_fetch_stall", {63'd0, fetch_stall}, 64'd0);
        @(negedge clk);
        #1;
        check("after_busy_id_pc", {32'd0, id_pc}, 64'h10);
        check("after_busy_id_inst", {32'd0, id_inst}, {32'd0, mem_word(32'h10)});

        exp_push(32'h14);
        exp_push(32'h18);
        exp_push(32'h1C);
        repeat (3) @(negedge clk);
        #1;
        check("pre_drain_addr", {32'd0, imem_addr}, 64'h20);

        // redirect while the request at 0x20 is pending
        imem_busywait = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h103;
        #1;
        check("branch_busy_stall", {63'd0, fetch_stall}, 64'd1);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("drain_state", {62'd0, dbg_state}, {62'd0, ST_DRAIN});
        check("drain_addr", {32'd0, imem_addr}, 64'h20);
        check("drain_read", {63'd0, imem_read}, 64'd1);
        check("drain_fetch_stall", {63'd0, fetch_stall}, 64'd1);
        check("drain_id_valid", {63'd0, id_valid}, 64'd0);
        check("drain_id_inst", {32'd0, id_inst}, {32'd0, NOP_INST});
        @(negedge clk);
        #1;
        check("drain_addr_hold", {32'd0, imem_addr}, 64'h20);
        @(negedge clk);
        imem_busywait = 1'b0;
        #1;
        check("drain_done_addr", {32'd0, imem_addr}, 64'h20);
        check("drain_done_stall", {63'd0, fetch_stall}, 64'd1);
        @(negedge clk);
        #1;
        check("post_drain_state", {62'd0, dbg_state}, {62'd0, ST_FETCH});
        check("post_drain_addr", {32'd0, imem_addr}, 64'h100);
        check("post_drain_id_valid", {63'd0, id_valid}, 64'd0);

        // redirect in a completing cycle: 0x104 is discarded
        exp_push(32'h100);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("cmp_branch_addr", {32'd0, imem_addr}, 64'h40);
        check("cmp_branch_id_valid", {63'd0, id_valid}, 64'd0);
        check("cmp_branch_state", {62'd0, dbg_state}, {62'd0, ST_FETCH});

        // two stall cycles while fetching 0x44
        exp_push(32'h40);
        exp_push(32'h44);
        @(negedge clk);
        stall = 1'b1;
        #1;
        check("stall1_read", {63'd0, imem_read}, 64'd1);
        check("stall1_addr", {32'd0, imem_addr}, 64'h44);
        @(negedge clk);
        #1;
        check("stall1_id_pc_held", {32'd0, id_pc}, 64'h40);
        check("stall2_read", {63'd0, imem_read}, {63'd0, !SKID_BUILD});
        @(negedge clk);
        stall = 1'b0;
        #1;
        check("stall2_id_pc_held", {32'd0, id_pc}, 64'h40);
        check("stall2_id_valid_held", {63'd0, id_valid}, 64'd1);
        check("release_read", {63'd0, imem_read}, {63'd0, !SKID_BUILD});
        @(negedge clk);
        #1;
        check("release_id_pc", {32'd0, id_pc}, 64'h44);
        check("release_next_addr", {32'd0, imem_addr}, 64'h48);
        check("release_next_read", {63'd0, imem_read}, 64'd1);

        // branch and stall together
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h200;
        @(negedge clk);
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        #1;
        check("br_stall_addr", {32'd0, imem_addr}, 64'h200);
        check("br_stall_id_valid", {63'd0, id_valid}, 64'd0);
        check("br_stall_id_inst", {32'd0, id_inst}, {32'd0, NOP_INST});

        // 32-bit PC wrap
        exp_push(32'hFFFF_FFFC);
        exp_push(32'h0);
        @(negedge clk);
        branch_taken = 1'b0;
        #1;
        check("wrap_addr", {32'd0, imem_addr}, 64'hFFFF_FFFC);
        check("addr_aligned", {62'd0, imem_addr[1:0]}, 64'd0);
        @(negedge clk);
        #1;
        check("wrap_id_pc4", {32'd0, id_pc4}, 64'd0);
        check("wrap_next_addr", {32'd0, imem_addr}, 64'd0);
        @(negedge clk);

        // random wait states
        exp_pc = 32'h4;
        for (int i = 0; i < 24; i++) begin
            b = $urandom_range(0, 1);
            imem_busywait = b[0];
            #1;
            check("rnd_fetch_stall", {63'd0, fetch_stall}, {63'd0, b[0]});
            check("rnd_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
            if (b == 0) begin
                exp_push(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            @(negedge clk);
        end

        // reset during DRAIN, overriding stall and branch
        imem_busywait = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h300;
        @(negedge clk);
        #1;
        check("rst_drain_state", {62'd0, dbg_state}, {62'd0, ST_DRAIN});
        check("rst_drain_addr", {32'd0, imem_addr}, {32'd0, exp_pc});
        reset = 1'b1;
        stall = 1'b1;
        branch_target = 32'h500;
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        branch_taken = 1'b0;
        #1;
        check("rst2_read", {63'd0, imem_read}, 64'd0);
        check("rst2_addr", {32'd0, imem_addr}, 64'd0);
        check("rst2_id_valid", {63'd0, id_valid}, 64'd0);
        check("rst2_state", {62'd0, dbg_state}, {62'd0, ST_BOOT});
        @(negedge clk);
        #1;
        check("rst2_fetch_addr", {32'd0, imem_addr}, 64'd0);
        check("rst2_fetch_read", {63'd0, imem_read}, 64'd1);
        @(negedge clk);
        #1;

        check("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
